ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits between ID and MEM.
- Registers the ID→EX bus and runs the 12-op ALU.
- Issues the data-SRAM request and returns the forwarding bus to ID.
- Adds HI/LO registers with iterative MULT/MULTU/DIV/DIVU. The stage stalls the pipeline while an iterative operation runs.

---
 rtl/ex_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID->EX register, one-hot ALU, data-SRAM
// request, forwarding bus, and HI/LO with an iterative 32-step multiplier/divider.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id_bus,
    output logic                    inst_is_lw,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    logic [ID_TO_EX_WD-1:0] ex_bus_q;

    logic [31:0] pc_s, inst_s, rdata1_s, rdata2_s;
    logic [11:0] alu_op_s;
    logic [2:0]  sel_src1_s;
    logic [3:0]  sel_src2_s, ram_wen_s;
    logic        ram_en_s, rf_we_s, sel_rf_res_s;
    logic [4:0]  rf_waddr_s;

    logic [31:0] src1_s, src2_s, alu_res_s, ex_result_s;
    logic [4:0]  shamt_s;

    logic        is_special_s, is_muldiv_s, md_signed_s, md_div_s;
    logic        is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s;
    logic        a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s;

    md_state_e   md_state_q;
    logic [5:0]  md_cnt_q;
    logic [63:0] md_acc_q;
    logic [31:0] md_b_q;
    logic        md_is_div_q, md_neg_q, md_neg_rem_q;

    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s, div_next_s, md_prod_s;
    logic [32:0] div_top_s;
    logic [33:0] div_diff_s;
    logic [31:0] md_quo_s, md_rem_s, md_hi_s, md_lo_s;

    logic [31:0] hi_q, lo_q;
    logic        unused_s;

    // ID->EX pipeline register: bubble, load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bus_q <= '0;
        end else if (stall[2] && !stall[3]) begin
            ex_bus_q <= '0;
        end else if (!stall[2]) begin
            ex_bus_q <= id_to_ex_bus;
        end else begin
            ex_bus_q <= ex_bus_q;
        end
    end

    assign pc_s         = ex_bus_q[158:127];
    assign inst_s       = ex_bus_q[126:95];
    assign alu_op_s     = ex_bus_q[94:83];
    assign sel_src1_s   = ex_bus_q[82:80];
    assign sel_src2_s   = ex_bus_q[79:76];
    assign ram_en_s     = ex_bus_q[75];
    assign ram_wen_s    = ex_bus_q[74:71];
    assign rf_we_s      = ex_bus_q[70];
    assign rf_waddr_s   = ex_bus_q[69:65];
    assign sel_rf_res_s = ex_bus_q[64];
    assign rdata1_s     = ex_bus_q[63:32];
    assign rdata2_s     = ex_bus_q[31:0];

    // Operand selection and the one-hot ALU; an empty one-hot select yields 0.
    always_comb begin
        src1_s = ({32{sel_src1_s[0]}} & rdata1_s)
               | ({32{sel_src1_s[1]}} & pc_s)
               | ({32{sel_src1_s[2]}} & {27'd0, inst_s[10:6]});
        src2_s = ({32{sel_src2_s[0]}} & rdata2_s)
               | ({32{sel_src2_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
               | ({32{sel_src2_s[2]}} & 32'd8)
               | ({32{sel_src2_s[3]}} & {16'd0, inst_s[15:0]});
        shamt_s = src1_s[4:0];
        alu_res_s = ({32{alu_op_s[11]}} & (src1_s + src2_s))
                  | ({32{alu_op_s[10]}} & (src1_s - src2_s))
                  | ({32{alu_op_s[9]}}  & {31'd0, ($signed(src1_s) < $signed(src2_s))})
                  | ({32{alu_op_s[8]}}  & {31'd0, (src1_s < src2_s)})
                  | ({32{alu_op_s[7]}}  & (src1_s & src2_s))
                  | ({32{alu_op_s[6]}}  & ~(src1_s | src2_s))
                  | ({32{alu_op_s[5]}}  & (src1_s | src2_s))
                  | ({32{alu_op_s[4]}}  & (src1_s ^ src2_s))
                  | ({32{alu_op_s[3]}}  & (src2_s << shamt_s))
                  | ({32{alu_op_s[2]}}  & (src2_s >> shamt_s))
                  | ({32{alu_op_s[1]}}  & 32'($signed(src2_s) >>> shamt_s))
                  | ({32{alu_op_s[0]}}  & {src2_s[15:0], 16'd0});
    end

    assign is_special_s = (inst_s[31:26] == 6'd0);
    assign is_muldiv_s  = is_special_s && (inst_s[5:2] == 4'b0110);
    assign md_signed_s  = !inst_s[0];
    assign md_div_s     = inst_s[1];
    assign is_mfhi_s    = is_special_s && (inst_s[5:0] == 6'h10);
    assign is_mthi_s    = is_special_s && (inst_s[5:0] == 6'h11);
    assign is_mflo_s    = is_special_s && (inst_s[5:0] == 6'h12);
    assign is_mtlo_s    = is_special_s && (inst_s[5:0] == 6'h13);

    // Operand magnitudes for the iterative unit; signs are reapplied on completion.
    always_comb begin
        a_neg_s = md_signed_s && rdata1_s[31];
        b_neg_s = md_signed_s && rdata2_s[31];
        a_mag_s = a_neg_s ? (32'd0 - rdata1_s) : rdata1_s;
        b_mag_s = b_neg_s ? (32'd0 - rdata2_s) : rdata2_s;
    end

    // One shift-add multiply step and one restoring-divide step on the shared accumulator.
    always_comb begin
        mul_sum_s  = {1'b0, md_acc_q[63:32]} + (md_acc_q[0] ? {1'b0, md_b_q} : 33'd0);
        mul_next_s = {mul_sum_s, md_acc_q[31:1]};
        div_top_s  = md_acc_q[63:31];
        div_diff_s = {1'b0, div_top_s} - {2'b00, md_b_q};
        if (!div_diff_s[33]) begin
            div_next_s = {div_diff_s[31:0], md_acc_q[30:0], 1'b1};
        end else begin
            div_next_s = {div_top_s[31:0], md_acc_q[30:0], 1'b0};
        end
    end

    // Final HI/LO values after sign correction.
    always_comb begin
        md_prod_s = md_neg_q ? (64'd0 - md_acc_q) : md_acc_q;
        md_quo_s  = md_neg_q ? (32'd0 - md_acc_q[31:0]) : md_acc_q[31:0];
        md_rem_s  = md_neg_rem_q ? (32'd0 - md_acc_q[63:32]) : md_acc_q[63:32];
        if (md_is_div_q) begin
            md_hi_s = md_rem_s;
            md_lo_s = md_quo_s;
        end else begin
            md_hi_s = md_prod_s[63:32];
            md_lo_s = md_prod_s[31:0];
        end
    end

    // Mul/div sequencer: latch operands, iterate 32 times, then wait for EX to advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_state_q   <= MD_IDLE;
            md_cnt_q     <= 6'd0;
            md_acc_q     <= 64'd0;
            md_b_q       <= 32'd0;
            md_is_div_q  <= 1'b0;
            md_neg_q     <= 1'b0;
            md_neg_rem_q <= 1'b0;
        end else begin
            case (md_state_q)
                MD_IDLE: begin
                    if (is_muldiv_s) begin
                        md_state_q   <= MD_BUSY;
                        md_cnt_q     <= 6'd0;
                        md_acc_q     <= {32'd0, (md_div_s ? a_mag_s : b_mag_s)};
                        md_b_q       <= md_div_s ? b_mag_s : a_mag_s;
                        md_is_div_q  <= md_div_s;
                        md_neg_q     <= a_neg_s ^ b_neg_s;
                        md_neg_rem_q <= a_neg_s;
                    end
                end
                MD_BUSY: begin
                    md_acc_q <= md_is_div_q ? div_next_s : mul_next_s;
                    md_cnt_q <= md_cnt_q + 6'd1;
                    if (md_cnt_q == 6'd31) begin
                        md_state_q <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!stall[2]) begin
                        md_state_q <= MD_IDLE;
                    end
                end
                default: begin
                    md_state_q <= MD_IDLE;
                end
            endcase
        end
    end

    // HI/LO: mul/div results commit when the instruction leaves EX, as do mthi/mtlo.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if ((md_state_q == MD_DONE) && !stall[2]) begin
            hi_q <= md_hi_s;
            lo_q <= md_lo_s;
        end else if (!stall[2] && is_mthi_s) begin
            hi_q <= rdata1_s;
        end else if (!stall[2] && is_mtlo_s) begin
            lo_q <= rdata1_s;
        end
    end

    assign stallreq_for_ex = ((md_state_q == MD_IDLE) && is_muldiv_s) || (md_state_q == MD_BUSY);

    assign ex_result_s     = is_mfhi_s ? hi_q : (is_mflo_s ? lo_q : alu_res_s);
    assign ex_to_mem_bus   = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s, ex_result_s};
    assign ex_to_id_bus    = {rf_we_s, rf_waddr_s, ex_result_s};
    assign inst_is_lw      = ram_en_s & sel_rf_res_s;
    assign data_sram_en    = ram_en_s;
    assign data_sram_wen   = ram_wen_s;
    assign data_sram_addr  = alu_res_s;
    assign data_sram_wdata = rdata2_s;

    assign unused_s = ^{stall[STALL_WD-1:4], stall[1:0], inst_s[25:16], div_diff_s[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected EX outputs, a reference
// ALU and a 64-bit arithmetic model of the HI/LO operations.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         inst_is_lw, data_sram_en, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id_bus(ex_to_id_bus), .inst_is_lw(inst_is_lw),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .stallreq_for_ex(stallreq_for_ex)
    );

    always #5 clk = ~clk;

    localparam logic [2:0]  S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
    localparam logic [3:0]  S2_RT = 4'b0001, S2_SEXT = 4'b0010, S2_8 = 4'b0100, S2_ZEXT = 4'b1000;
    localparam logic [11:0] OP_ADD = 12'h800, OP_OR = 12'h020;
    localparam int P_FWD = 0, P_ADDR = 1, P_WDATA = 2, P_MEMCTL = 3, P_LW = 4,
                   P_STALLREQ = 5, P_MEM_LO = 6, P_MEM_PC = 7;

    typedef struct {
        string       tag;
        int          probe;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] probe_val(input int p);
        case (p)
            P_FWD:      probe_val = {26'd0, ex_to_id_bus};
            P_ADDR:     probe_val = {32'd0, data_sram_addr};
            P_WDATA:    probe_val = {32'd0, data_sram_wdata};
            P_MEMCTL:   probe_val = {59'd0, data_sram_en, data_sram_wen};
            P_LW:       probe_val = {63'd0, inst_is_lw};
            P_STALLREQ: probe_val = {63'd0, stallreq_for_ex};
            P_MEM_LO:   probe_val = {20'd0, ex_to_mem_bus[43:0]};
            P_MEM_PC:   probe_val = {32'd0, ex_to_mem_bus[75:44]};
            default:    probe_val = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int p, input logic [63:0] v);
        sb_t e;
        e.tag = tag;
        e.probe = p;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, probe_val(e.probe), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [158:0] b);
        id_to_ex_bus = b;
        stall = 6'd0;
        step();
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] rwen, input logic we,
                                        input logic [4:0] waddr, input logic srf,
                                        input logic [31:0] r1, input logic [31:0] r2);
        mk = {pc, inst, op, s1, s2, ren, rwen, we, waddr, srf, r1, r2};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        rtype = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, funct};
    endfunction

    function automatic logic [31:0] alu_ref(input int k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            0:       alu_ref = a + b;
            1:       alu_ref = a - b;
            2:       alu_ref = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:       alu_ref = (a < b) ? 32'd1 : 32'd0;
            4:       alu_ref = a & b;
            5:       alu_ref = ~(a | b);
            6:       alu_ref = a | b;
            7:       alu_ref = a ^ b;
            8:       alu_ref = b << a[4:0];
            9:       alu_ref = b >> a[4:0];
            10:      alu_ref = 32'($signed(b) >>> a[4:0]);
            default: alu_ref = {b[15:0], 16'd0};
        endcase
    endfunction

    // Returns {HI, LO}.
    function automatic logic [63:0] md_ref(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        int sa, sb;
        sa = a;
        sb = b;
        case (funct)
            6'h18: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                md_ref = sp;
            end
            6'h19: md_ref = {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) md_ref = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                else            md_ref = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) md_ref = {a, 32'hFFFF_FFFF};
                else            md_ref = {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [158:0] mf_bus(input logic [5:0] funct);
        mf_bus = mk(32'd0, rtype(funct), 12'd0, S1_RS, S2_RT, 1'b0, 4'd0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
    endfunction

    task automatic mf(input string tag, input logic [5:0] funct, input logic [31:0] exp);
        expect_out(tag, P_FWD, {26'd0, 1'b1, 5'd8, exp});
        drive(mf_bus(funct));
        drain();
    endtask

    task automatic mt(input logic [5:0] funct, input logic [31:0] val);
        drive(mk(32'd0, rtype(funct), 12'd0, S1_RS, S2_RT, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, val, 32'd0));
        if (funct == 6'h11) model_hi = val;
        else                model_lo = val;
    endtask

    // Issue a mul/div, follow it with mfhi/mflo, optionally hold it in DONE.
    task automatic md_test(input string tag, input logic [5:0] funct, input logic [31:0] a,
                           input logic [31:0] b, input logic hi_first, input int hold);
        logic [63:0]  r;
        logic [158:0] follow;
        int           cyc;
        r = md_ref(funct, a, b);
        follow = mf_bus(hi_first ? 6'h10 : 6'h12);
        expect_out({tag, "_first"}, P_FWD, {26'd0, 1'b1, 5'd8, (hi_first ? r[63:32] : r[31:0])});
        id_to_ex_bus = mk(32'd0, rtype(funct), 12'd0, S1_RS, S2_RT, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, a, b);
        stall = 6'd0;
        step();
        cyc = 0;
        for (int i = 0; i < 100 && stallreq_for_ex; i++) begin
            cyc++;
            stall = 6'b001111;
            id_to_ex_bus = follow;
            step();
        end
        chk({tag, "_stall_cycles"}, 64'(cyc), 64'd33);
        for (int h = 0; h < hold; h++) begin
            stall = 6'b001111;
            step();
            chk({tag, "_done_no_restart"}, {63'd0, stallreq_for_ex}, 64'd0);
            chk({tag, "_done_hold_hi"}, {32'd0, dut.hi_q}, {32'd0, model_hi});
            chk({tag, "_done_hold_lo"}, {32'd0, dut.lo_q}, {32'd0, model_lo});
        end
        stall = 6'd0;
        id_to_ex_bus = follow;
        step();
        drain();
        model_hi = r[63:32];
        model_lo = r[31:0];
        if (hi_first) mf({tag, "_lo"}, 6'h12, model_lo);
        else          mf({tag, "_hi"}, 6'h10, model_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [158:0] b;
        logic [31:0]  a, bb, s1, s2;
        logic [11:0]  op;

        rst = 1'b1;
        stall = 6'd0;
        id_to_ex_bus = mk(32'hBFC00010, rtype(6'h21), OP_ADD, S1_RS, S2_RT, 1'b1, 4'hF, 1'b1, 5'd3, 1'b1, 32'h5, 32'h6);
        step();
        step();
        expect_out("rst_fwd", P_FWD, 64'd0);
        expect_out("rst_mem", P_MEM_LO, 64'd0);
        expect_out("rst_mem_pc", P_MEM_PC, 64'd0);
        expect_out("rst_memctl", P_MEMCTL, 64'd0);
        expect_out("rst_stallreq", P_STALLREQ, 64'd0);
        drain();
        rst = 1'b0;

        b = mk(32'hBFC00010, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, OP_ADD, S1_RS, S2_RT,
               1'b0, 4'd0, 1'b1, 5'd3, 1'b0, 32'h7FFF_FFFF, 32'h1);
        expect_out("addu_fwd", P_FWD, {26'd0, 1'b1, 5'd3, 32'h8000_0000});
        expect_out("addu_mem", P_MEM_LO, {20'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'h8000_0000});
        expect_out("addu_pc", P_MEM_PC, 64'hBFC00010);
        expect_out("addu_memctl", P_MEMCTL, 64'd0);
        drive(b);
        drain();

        b = mk(32'hBFC00014, {6'h2B, 5'd1, 5'd2, 16'hFFFC}, OP_ADD, S1_RS, S2_SEXT,
               1'b1, 4'b1111, 1'b0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF);
        expect_out("sw_addr", P_ADDR, 64'h0000_00FC);
        expect_out("sw_wdata", P_WDATA, 64'hDEAD_BEEF);
        expect_out("sw_memctl", P_MEMCTL, 64'h1F);
        expect_out("sw_is_lw", P_LW, 64'd0);
        drive(b);
        drain();

        b = mk(32'hBFC00018, {6'h23, 5'd1, 5'd9, 16'h0008}, OP_ADD, S1_RS, S2_SEXT,
               1'b1, 4'd0, 1'b1, 5'd9, 1'b1, 32'h200, 32'h0);
        expect_out("lw_is_lw", P_LW, 64'd1);
        expect_out("lw_memctl", P_MEMCTL, 64'h10);
        expect_out("lw_fwd", P_FWD, {26'd0, 1'b1, 5'd9, 32'h208});
        drive(b);
        drain();

        b = mk(32'hBFC0001C, {6'h0D, 5'd1, 5'd4, 16'h8001}, OP_OR, S1_RS, S2_ZEXT,
               1'b0, 4'd0, 1'b1, 5'd4, 1'b0, 32'h1234_0000, 32'h0);
        expect_out("ori_zext", P_FWD, {26'd0, 1'b1, 5'd4, 32'h1234_8001});
        drive(b);
        drain();

        b = mk(32'hBFC00020, {6'h03, 26'd0}, OP_ADD, S1_PC, S2_8,
               1'b0, 4'd0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
        expect_out("jal_link", P_FWD, {26'd0, 1'b1, 5'd31, 32'hBFC0_0028});
        drive(b);
        drain();

        for (int k = 0; k < 12; k++) begin
            a = $urandom;
            bb = $urandom;
            op = 12'h800 >> k;
            if (k >= 8 && k <= 10) begin
                s1 = {27'd0, a[4:0]};
                s2 = bb;
                b = mk(32'd0, {6'd0, 5'd0, 5'd2, 5'd3, a[4:0], 6'h00}, op, S1_SA, S2_RT,
                       1'b0, 4'd0, 1'b1, 5'd3, 1'b0, 32'h0, bb);
            end else if (k == 11) begin
                s1 = a;
                s2 = {16'd0, bb[15:0]};
                b = mk(32'd0, {6'h0F, 5'd0, 5'd3, bb[15:0]}, op, S1_RS, S2_ZEXT,
                       1'b0, 4'd0, 1'b1, 5'd3, 1'b0, a, 32'h0);
            end else begin
                s1 = a;
                s2 = bb;
                b = mk(32'd0, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, op, S1_RS, S2_RT,
                       1'b0, 4'd0, 1'b1, 5'd3, 1'b0, a, bb);
            end
            expect_out($sformatf("alu_op%0d", k), P_FWD, {26'd0, 1'b1, 5'd3, alu_ref(k, s1, s2)});
            drive(b);
            drain();
        end

        b = mk(32'h40, rtype(6'h21), OP_ADD, S1_RS, S2_RT, 1'b0, 4'd0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd6);
        expect_out("hold_load", P_FWD, {26'd0, 1'b1, 5'd3, 32'd11});
        drive(b);
        drain();
        stall = 6'b001111;
        id_to_ex_bus = mk(32'h44, rtype(6'h21), OP_ADD, S1_RS, S2_RT, 1'b1, 4'hF, 1'b1, 5'd3, 1'b0, 32'd100, 32'd1);
        step();
        expect_out("hold_keep", P_FWD, {26'd0, 1'b1, 5'd3, 32'd11});
        drain();
        stall = 6'b000111;
        step();
        expect_out("bubble_fwd", P_FWD, 64'd0);
        expect_out("bubble_mem", P_MEM_LO, 64'd0);
        expect_out("bubble_pc", P_MEM_PC, 64'd0);
        expect_out("bubble_memctl", P_MEMCTL, 64'd0);
        expect_out("bubble_addr", P_ADDR, 64'd0);
        expect_out("bubble_wdata", P_WDATA, 64'd0);
        drain();
        expect_out("after_bubble", P_FWD, {26'd0, 1'b1, 5'd3, 32'd101});
        drive(id_to_ex_bus);
        drain();

        mt(6'h11, 32'h1234_5678);
        mt(6'h13, 32'h9ABC_DEF0);
        mf("mthi_mfhi", 6'h10, 32'h1234_5678);
        mf("mtlo_mflo", 6'h12, 32'h9ABC_DEF0);

        md_test("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        md_test("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        md_test("divu_by0", 6'h1B, 32'd5, 32'd0, 1'b0, 0);
        md_test("div_by0_neg", 6'h1A, 32'hFFFF_FFFB, 32'd0, 1'b0, 0);
        md_test("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7, 1'b1, 0);
        for (int i = 0; i < 2; i++) begin
            a = $urandom;
            bb = $urandom_range(2, 65535);
            if ($urandom_range(0, 1) == 1) bb = 32'd0 - bb;
            md_test($sformatf("div_rand%0d", i), 6'h1A, a, bb, 1'b0, 0);
            md_test($sformatf("mult_rand%0d", i), 6'h18, a, bb, 1'b1, 0);
        end

        mt(6'h11, 32'hAAAA_AAAA);
        md_test("done_hold", 6'h18, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 3);

        id_to_ex_bus = mk(32'd0, rtype(6'h18), 12'd0, S1_RS, S2_RT, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'd3, 32'd5);
        stall = 6'd0;
        step();
        stall = 6'b001111;
        repeat (11) step();
        chk("busy_before_rst", {63'd0, stallreq_for_ex}, 64'd1);
        rst = 1'b1;
        id_to_ex_bus = '0;
        stall = 6'd0;
        step();
        rst = 1'b0;
        chk("rst_mid_stallreq", {63'd0, stallreq_for_ex}, 64'd0);
        chk("rst_mid_hi", {32'd0, dut.hi_q}, 64'd0);
        chk("rst_mid_lo", {32'd0, dut.lo_q}, 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        mf("rst_mid_mfhi", 6'h10, 32'd0);
        mf("rst_mid_mflo", 6'h12, 32'd0);
        md_test("after_rst_multu", 6'h19, 32'd123456, 32'd7890, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
